// File: rtl/alu_seq_pkg.sv
// Shared constants, opcode map and FSM state type for the ALU sequencer.
package alu_seq_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_LAST = OP_SHR;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp
    } seq_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: two combinational read ports, one synchronous write port,
// asynchronously cleared.
module alu_seq_regfile #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RF_DEPTH = 4,
    localparam int unsigned IW      = $clog2(RF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IW-1:0]     rd_addr_a_i,
    input  logic [IW-1:0]     rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [RF_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = mem_q[rd_addr_b_i];

endmodule

// File: rtl/alu_seq_driver.sv
// Command-driven sequencer for the external combinational ALU.
// Define ALU_SEQ_FLAGS_EN to add the rsp_zero / rsp_carry response flags.
module alu_seq_driver
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned RF_DEPTH = 4,
    localparam int unsigned IW      = $clog2(RF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [3:0]        cmd_op,
    input  logic [IW-1:0]     cmd_dst,
    input  logic [IW-1:0]     cmd_srca,
    input  logic [IW-1:0]     cmd_srcb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_mode,
    input  logic [DATA_W:0]   alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W:0]   rsp_data,
    output logic              rsp_err
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              rsp_zero,
    output logic              rsp_carry
`endif
);

    seq_state_t        state_q;
    logic [IW-1:0]     dst_q;
    logic [DATA_W-1:0] rd_a, rd_b, wr_data;
    logic [IW-1:0]     wr_addr;
    logic              wr_en;
    logic              accept;

    // Held low during reset so no command can be taken while the block is cleared.
    assign cmd_ready = rst_n && (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cmd_dst;
        wr_data = cmd_imm;
        if (accept && cmd_load) begin
            wr_en = 1'b1;
        end else if (state_q == StCapture) begin
            wr_en   = 1'b1;
            wr_addr = dst_q;
            wr_data = alu_out[DATA_W-1:0];
        end
    end

    alu_seq_regfile #(
        .DATA_W   (DATA_W),
        .RF_DEPTH (RF_DEPTH)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_a_i (cmd_srca),
        .rd_addr_b_i (cmd_srcb),
        .rd_data_a_o (rd_a),
        .rd_data_b_o (rd_b),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            dst_q    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (cmd_load) begin
                            rsp_data <= {1'b0, cmd_imm};
                            rsp_err  <= 1'b0;
                            state_q  <= StResp;
                        end else if (!op_is_legal(cmd_op)) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            state_q  <= StResp;
                        end else begin
                            // Operands latched here, so a source equal to dst sees the old value.
                            alu_a    <= rd_a;
                            alu_b    <= rd_b;
                            alu_mode <= cmd_op;
                            dst_q    <= cmd_dst;
                            rsp_err  <= 1'b0;
                            state_q  <= StIssue;
                        end
                    end
                end
                StIssue: state_q <= StCapture;
                StCapture: begin
                    rsp_data <= alu_out;
                    state_q  <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
        end else if (accept) begin
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
        end else if (state_q == StCapture) begin
            rsp_zero  <= (alu_out[DATA_W-1:0] == '0);
            rsp_carry <= alu_out[DATA_W];
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_driver.sv
// Randomised self-checking bench for alu_seq_driver with a behavioural ALU and
// an array-based reference model of the register file.
module tb_alu_seq_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_load;
    logic [3:0]  cmd_op;
    logic [1:0]  cmd_dst, cmd_srca, cmd_srcb;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_mode;
    logic [16:0] alu_out;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [16:0] rsp_data;
`ifdef ALU_SEQ_FLAGS_EN
    logic        rsp_zero, rsp_carry;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] rf_model [4];

    always #5 clk = ~clk;

    function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] m);
        case (m)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a} + 17'd1;
            4'd3:    return {1'b0, a} - 17'd1;
            4'd4:    return {1'b0, a & b};
            4'd5:    return {1'b0, a | b};
            4'd6:    return {1'b0, a ^ b};
            4'd7:    return {1'b0, ~a};
            4'd8:    return {a, 1'b0};
            4'd9:    return {2'b00, a[15:1]};
            default: return 17'd0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_mode);

    alu_seq_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst rsp_data", {15'd0, rsp_data}, 32'd0);
        check("rst alu_a", {16'd0, alu_a}, 32'd0);
        check("rst alu_b", {16'd0, alu_b}, 32'd0);
        check("rst alu_mode", {28'd0, alu_mode}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        check("rst flags", {30'd0, rsp_zero, rsp_carry}, 32'd0);
`endif
    endtask

    // One full command: handshake, latency, response contents, back-pressure, retire.
    task automatic run_cmd(input logic ld, input logic [3:0] op, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb,
                           input logic [15:0] imm, input int hold, input logic early);
        logic [16:0] exp_d, held;
        logic        exp_e, exec;
        logic [15:0] va, vb;
        int          lat, want;
        va   = rf_model[sa];
        vb   = rf_model[sb];
        exec = !ld && (op <= 4'd9);
        if (ld) begin
            exp_d = {1'b0, imm};
            exp_e = 1'b0;
            rf_model[dst] = imm;
        end else if (!exec) begin
            exp_d = 17'd0;
            exp_e = 1'b1;
        end else begin
            exp_d = alu_fn(va, vb, op);
            exp_e = 1'b0;
            rf_model[dst] = exp_d[15:0];
        end
        want = exec ? 3 : 1;

        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_dst = dst;
        cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
        check("cmd_ready idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_imm   = 16'($urandom);
        cmd_srca  = 2'($urandom);
        cmd_srcb  = 2'($urandom);
        if (early) rsp_ready = 1'b1;
        check("cmd_ready busy", {31'd0, cmd_ready}, 32'd0);
        if (exec) begin
            check("issue alu_a", {16'd0, alu_a}, {16'd0, va});
            check("issue alu_b", {16'd0, alu_b}, {16'd0, vb});
            check("issue alu_mode", {28'd0, alu_mode}, {28'd0, op});
        end
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("rsp latency", lat, want);
        check("rsp_data", {15'd0, rsp_data}, {15'd0, exp_d});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
`ifdef ALU_SEQ_FLAGS_EN
        check("rsp flags", {30'd0, rsp_zero, rsp_carry},
              exec ? {30'd0, exp_d[15:0] == 16'd0, exp_d[16]} : 32'd0);
`endif
        held = rsp_data;
        if (!early) begin
            repeat (hold) @(negedge clk);
            check("rsp held valid", {31'd0, rsp_valid}, 32'd1);
            check("rsp held data", {15'd0, rsp_data}, {15'd0, held});
            check("rsp held cmd_ready", {31'd0, cmd_ready}, 32'd0);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check("retire rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("retire cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0;
        cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; cmd_imm = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) rf_model[i] = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        check("post-reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);

        // Directed scenarios.
        run_cmd(1, 4'd0, 2'd0, 2'd0, 2'd0, 16'd5, 0, 0);
        run_cmd(1, 4'd0, 2'd1, 2'd0, 2'd0, 16'd6, 0, 0);
        run_cmd(0, 4'd0, 2'd2, 2'd0, 2'd1, 16'd0, 0, 0);
        run_cmd(1, 4'd0, 2'd0, 2'd0, 2'd0, 16'd8, 0, 0);
        run_cmd(0, 4'd1, 2'd2, 2'd0, 2'd1, 16'd0, 0, 0);
        run_cmd(1, 4'd0, 2'd0, 2'd0, 2'd0, 16'd3, 0, 0);
        run_cmd(1, 4'd0, 2'd1, 2'd0, 2'd0, 16'd5, 0, 0);
        run_cmd(0, 4'd1, 2'd2, 2'd0, 2'd1, 16'd0, 0, 0);
        run_cmd(0, 4'd5, 2'd3, 2'd2, 2'd2, 16'd0, 0, 0);
        run_cmd(1, 4'd0, 2'd3, 2'd0, 2'd0, 16'hC, 0, 0);
        run_cmd(0, 4'd7, 2'd3, 2'd3, 2'd1, 16'd0, 0, 0);
        run_cmd(0, 4'd5, 2'd0, 2'd3, 2'd3, 16'd0, 0, 0);
        run_cmd(0, 4'hC, 2'd2, 2'd0, 2'd1, 16'd0, 0, 0);
        run_cmd(0, 4'd0, 2'd1, 2'd2, 2'd0, 16'd0, 0, 0);
        run_cmd(1, 4'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 5, 0);
        run_cmd(0, 4'd2, 2'd1, 2'd0, 2'd0, 16'd0, 0, 1);
        run_cmd(1, 4'd0, 2'd2, 2'd0, 2'd0, 16'h1234, 0, 1);

        // Reset asserted while the execute is in CAPTURE.
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 4'd0;
        cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        for (int i = 0; i < 4; i++) rf_model[i] = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        run_cmd(0, 4'd0, 2'd0, 2'd0, 2'd1, 16'd0, 0, 0);
        run_cmd(0, 4'd5, 2'd1, 2'd2, 2'd3, 16'd0, 0, 0);
        run_cmd(1, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0, 0, 0);
        run_cmd(1, 4'd0, 2'd1, 2'd0, 2'd0, 16'd0, 0, 0);
        run_cmd(0, 4'd6, 2'd2, 2'd0, 2'd1, 16'd0, 0, 0);

        // Randomised mix of loads, legal and illegal ops, stalls and early ready.
        for (int n = 0; n < 120; n++) begin
            logic       ld;
            logic [3:0] op;
            ld = ($urandom_range(0, 2) == 0);
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 9));
            run_cmd(ld, op, 2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom),
                    $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_driver.md
# alu_seq_driver

Command-driven initiator for the 16-bit ALU. Accepts operation commands over a valid/ready stream, fetches operands from a local 4 x 16 register file, drives the ALU's `A`/`B`/`mode` inputs, captures the 17-bit result, writes it back and returns it on a response stream. Sits between the control path and the combinational ALU and replaces hand-sequenced operand driving.

## Interface

**Parameters**
- `DATA_W`, default 16: operand width. The ALU result is `DATA_W+1` bits.
- `RF_DEPTH`, default 4: register file entries. Must be a power of 2. Index width `IW = log2(RF_DEPTH)`.

**Ports** (name, direction, width, meaning)
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_load` in 1: 1 = write `cmd_imm` to `rf[cmd_dst]`; 0 = execute ALU op.
- `cmd_op` in 4: ALU mode.
- `cmd_dst`, `cmd_srca`, `cmd_srcb` in IW each: register indices.
- `cmd_imm` in DATA_W: immediate for loads.
- `alu_a`, `alu_b` out DATA_W: to ALU `A` and `B`.
- `alu_mode` out 4: to ALU `mode`.
- `alu_out` in DATA_W+1: from ALU.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out DATA_W+1: result, or `{1'b0, imm}` for loads.
- `rsp_err` out 1: illegal opcode.

## Operation

- **Opcode map:**
  - 0 ADD
  - 1 SUB
  - 2 INC A
  - 3 DEC A
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT A
  - 8 SHL A
  - 9 SHR A
  - 10–15 illegal.
- **FSM states:** IDLE, ISSUE, CAPTURE, RESP.
- **IDLE:**
  - `cmd_ready` = 1.
  - On handshake with `cmd_load` = 1: write `rf[dst]` = `imm`, load the response `{0, imm}` with `rsp_err` = 0, go to RESP.
  - On handshake with `cmd_load` = 0 and an illegal op: `rsp_data` = 0, `rsp_err` = 1, register file untouched, go to RESP.
  - Otherwise: register `alu_a` = `rf[srca]`, `alu_b` = `rf[srcb]`, `alu_mode` = `op`, go to ISSUE.
- **ISSUE:** one settle cycle for the ALU. Always go to CAPTURE.
- **CAPTURE:**
  - `rsp_data` = `alu_out`.
  - `rf[dst]` = `alu_out[DATA_W-1:0]`.
  - Go to RESP.
- **RESP:**
  - `rsp_valid` = 1. Hold `rsp_data` and `rsp_err` stable.
  - On `rsp_ready`, go to IDLE.
- `cmd_ready` is 0 in every state except IDLE. There is no command overlap.
- **Unary ops:** `alu_b` is still driven with `rf[srcb]`; the ALU ignores it.
- **Register file access:**
  - Reads are combinational in IDLE only.
  - Writes happen at the end of the load-accept cycle or the CAPTURE cycle.
  - When `srca` or `srcb` equals `dst`, the old value is read (operands are latched before writeback).
- **Reset values** (asserted asynchronously, mid-operation included):
  - State = IDLE.
  - `cmd_ready` = 1 after reset deasserts. It is 0 while `rst_n` is low.
  - `rsp_valid`, `rsp_err` = 0.
  - `rsp_data`, `alu_a`, `alu_b` = 0.
  - `alu_mode` = 0.
  - All register file entries = 0.
  - Any in-flight command is dropped.

## Timing

- Load: handshake at edge N, then `rsp_valid` = 1 after edge N.
- Execute:
  - Handshake at edge N.
  - ALU inputs valid after N.
  - Capture at N+2.
  - `rsp_valid` = 1 after N+2.
- Minimum command-to-command period:
  - Execute: 4 cycles (including one IDLE).
  - Load: 2 cycles.
- When `rsp_ready` is held high while `rsp_valid` rises, the response retires on the next edge. A `rsp_ready` pulse that arrives before `rsp_valid` is ignored.
- `alu_a`, `alu_b`, `alu_mode` hold their last values outside ISSUE and CAPTURE.

## Configuration

- **`ALU_SEQ_FLAGS_EN` defined:**
  - Adds output ports `rsp_zero` (1) and `rsp_carry` (1), registered with `rsp_data`.
  - `rsp_zero` = (`rsp_data[DATA_W-1:0]` == 0).
  - `rsp_carry` = `rsp_data[DATA_W]`.
  - Both are 0 for loads, for errors and at reset.
- **Not defined:** these ports and their logic are absent. All other behaviour is identical.

## Structure

- Package `alu_seq_pkg`:
  - `DATA_W` default.
  - Opcode constants `OP_ADD` through `OP_SHR`, and `OP_LAST` = 9.
  - FSM state enum `seq_state_t`.
- Sub-module `alu_seq_regfile`: `RF_DEPTH` x `DATA_W`, 2 combinational read ports, 1 synchronous write port, asynchronous clear on `rst_n`.
- The top level holds the FSM, operand/mode registers and response registers. The ALU is instantiated outside the block; the bench connects it.

## Test plan

- Load r0 = 5, r1 = 6, then ADD dst = r2, a = r0, b = r1 -> `rsp_data` = 0x0000B; `alu_a` = 5 and `alu_b` = 6 during ISSUE; `rsp_valid` exactly 3 cycles after the execute handshake.
- Load r0 = 8, r1 = 6, SUB -> 0x00002. Then r0 = 3, r1 = 5, SUB -> low 16 bits 0xFFFE in r2, with ALU-defined bit 16 passed through unchanged.
- Load r3 = 0xC, NOT a = r3, dst = r3 -> result reflects the old r3 (0x000C) as operand; r3 is overwritten afterwards.
- `cmd_op` = 0xC -> `rsp_err` = 1, `rsp_data` = 0, no register file change; the next ADD works normally.
- Hold `rsp_ready` = 0 for 5 cycles in RESP -> `rsp_data` stable, `cmd_ready` = 0; the response retires one edge after `rsp_ready` rises.
- Assert `rst_n` low during CAPTURE -> all outputs take reset values immediately; after release, `cmd_ready` = 1 and the register file reads 0. With `ALU_SEQ_FLAGS_EN`, loading r0 = r1 = 0 then XOR gives `rsp_zero` = 1.
